// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the error-response state type used by the
// RAM lane controller and its byte-enable decoder.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_e;

endpackage

// File: rtl/ahb_be_decode.sv
// Little-endian byte-lane enable decode from HSIZE and the low address bits;
// flags sizes or alignments the lane RAMs cannot service.
module ahb_be_decode
    import ahb_lite_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] be,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no path leaves a
    // value held over from a previous evaluation, which would infer a latch.
    always_comb begin
        be      = 4'b0000;
        illegal = 1'b0;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                if (addr_lo[0]) illegal = 1'b1;
                else            be      = 4'b0011 << {addr_lo[1], 1'b0};
            end
            HSIZE_WORD: begin
                if (addr_lo != 2'b00) illegal = 1'b1;
                else                  be      = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_ram_lane_ctrl.sv
// AHB-Lite slave front-end for four byte-lane dual-port RAMs, with
// read-during-write forwarding and a two-cycle ERROR response.
module ahb_ram_lane_ctrl
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_q
);

    logic [3:0]            dec_be;
    logic                  dec_illegal;
    logic                  accept, acc_bad, acc_wr, acc_rd, fwd_hit;
    logic [ADDR_WIDTH-1:0] addr_word;

    logic                  wr_pend, rd_pend;
    logic [3:0]            wr_be, fwd_be;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           fwd_data;
    err_state_e            state, state_next;

    // High address bits alias by design; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here.
    logic unused_ok;
    assign unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    ahb_be_decode u_be_decode (
        .size    (HSIZE),
        .addr_lo (HADDR[1:0]),
        .be      (dec_be),
        .illegal (dec_illegal)
    );

    assign accept    = HSEL & HTRANS[1] & HREADY;
    assign acc_bad   = accept & dec_illegal;
    assign acc_wr    = accept & ~dec_illegal & HWRITE;
    assign acc_rd    = accept & ~dec_illegal & ~HWRITE;
    assign addr_word = HADDR[ADDR_WIDTH+1:2];

    assign ram_read_addr  = addr_word;
    assign ram_write_addr = wr_addr;
    assign ram_we         = wr_pend ? wr_be : 4'b0000;
    assign ram_wdata      = (ram_we != 4'b0000) ? HWDATA : 32'h0;

    // The lanes return old data when read and written to the same word on one edge.
    assign fwd_hit = acc_rd && (ram_we != 4'b0000) && (wr_addr == addr_word);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
            wr_be    <= 4'b0000;
            wr_addr  <= '0;
            fwd_be   <= 4'b0000;
            fwd_data <= 32'h0;
        end else begin
            wr_pend <= acc_wr;
            rd_pend <= acc_rd;
            if (acc_wr) begin
                wr_addr <= addr_word;
                wr_be   <= dec_be;
            end
            if (HREADY) begin
                fwd_be <= fwd_hit ? ram_we : 4'b0000;
            end
            if (fwd_hit) begin
                fwd_data <= HWDATA;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_OKAY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = ST_OKAY;
        case (state)
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = acc_bad ? ST_ERR1 : ST_OKAY;
        endcase
    end

    assign HREADYOUT = (state != ST_ERR1);
    assign HRESP     = (state == ST_OKAY) ? HRESP_OKAY : HRESP_ERROR;

    always_comb begin
        HRDATA = 32'h0;
        if (rd_pend) begin
            for (int n = 0; n < 4; n++) begin
                HRDATA[8*n +: 8] = fwd_be[n] ? fwd_data[8*n +: 8] : ram_q[8*n +: 8];
            end
        end
    end

endmodule

// File: doc/ahb_ram_lane_ctrl.md
Name: ahb_ram_lane_ctrl

Overview:
- AHB-Lite slave front-end that drives the four byte-lane simple dual-port RAMs (lanes b0..b3, one per byte of a 32-bit word) in the MIPSfpga2 memory subsystem.
- Converts pipelined AHB address/data phases into per-lane write enables, write/read addresses and write data, and reassembles the lane outputs into HRDATA.
- Forwards write data over the RAMs' old-data read-during-write behaviour and signals AHB errors for misaligned or oversized accesses.

Parameters:
- ADDR_WIDTH, 6, word-address width of each lane RAM; the block decodes HADDR[ADDR_WIDTH+1:2].

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; bits above ADDR_WIDTH+1 are ignored, so the memory aliases.
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; other codes are illegal.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1 = ERROR.
- ram_read_addr  out  ADDR_WIDTH  shared read address to all lanes.
- ram_write_addr  out  ADDR_WIDTH  shared write address to all lanes.
- ram_we  out  4  per-lane write enable; bit n drives lane bn.
- ram_wdata  out  32  lane n receives bits [8n+7:8n].
- ram_q  in  32  concatenated lane outputs {b3,b2,b1,b0}; registered, 1-cycle read latency.

Behaviour:
- Accept: the address phase is taken when HSEL & HTRANS[1] & HREADY. Little-endian: byte n of the word is lane bn.
- Byte-enable decode, from HSIZE and HADDR[1:0]:
  - size 0: be = 1 << a[1:0].
  - size 1: requires a[0] = 0; be = 4'b0011 << (2·a[1]).
  - size 2: requires a[1:0] = 0; be = 4'b1111.
  - Any other case is misaligned or illegal and goes to the error path.
- Reads:
  - ram_read_addr = HADDR[ADDR_WIDTH+1:2] combinationally at all times.
  - The lane RAM registers the word at the accept edge. In the following data phase, HRDATA = ram_q with forwarded bytes substituted.
  - Zero wait states.
- Writes:
  - At accept, register the word address, be and valid.
  - Next cycle (data phase): ram_write_addr = registered address, ram_we = registered be, ram_wdata = HWDATA. Zero wait states.
  - ram_we = 0 in all other cycles.
- Read-during-write forwarding:
  - Condition: a read accepted in cycle T while ram_we ≠ 0 in T to the same word address. The lanes return old data for that word.
  - At T, latch fwd_be = ram_we and fwd_data = HWDATA.
  - In T+1, each byte n of HRDATA = fwd_data byte n when fwd_be[n] is set, else ram_q byte n.
  - fwd_be clears in the next accepted or idle cycle.
- Error FSM, states OKAY, ERR1, ERR2:
  - OKAY → ERR1 on an accepted illegal transfer. No RAM access occurs and a write is suppressed (ram_we stays 0).
  - ERR1: HREADYOUT = 0, HRESP = 1 → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1 → OKAY. A new transfer may be accepted in ERR2 per AHB; it is processed normally.
- Idle/busy transfers and HSEL = 0: no RAM writes; HREADYOUT = 1, HRESP = 0 (OKAY state).
- Reset values (async, immediate):
  - Outputs: HREADYOUT = 1, HRESP = 0, HRDATA = 0, ram_we = 0, ram_write_addr = 0, ram_wdata = 0 (follows HWDATA only when ram_we ≠ 0, else 0).
  - State: FSM = OKAY; write-pending, fwd_be and registered addresses = 0.
  - A write whose data phase is cut by reset is dropped.
- Back-to-back: write → write to the same word is handled correctly by the RAMs. Write → read to the same word is forwarded. Read → write needs no special handling.

Decomposition:
- Shared package ahb_lite_pkg:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE codes (BYTE, HALF, WORD).
  - HRESP codes (OKAY, ERROR).
  - Error FSM state enum.
- Sub-module ahb_be_decode: combinational; inputs HSIZE and HADDR[1:0], outputs be[3:0] and illegal.

Test Plan:
- Reset asserted mid write data phase (we active) → ram_we = 0 immediately; a later read of that word returns the preload value.
- Word write 0xDEADBEEF @0x10, then idle, then word read @0x10 → HRDATA = 0xDEADBEEF, zero wait, HRESP = 0.
- Byte write 0xAA @0x13 (size 0) → ram_we = 4'b1000, ram_write_addr = 4; a read of 0x10 returns 0xAAADBEEF.
- Word write 0x11223344 @0x20 immediately followed by word read @0x20 → HRDATA = 0x11223344 via forwarding. Same sequence with halfword 0x5566 @0x22 → only the upper two bytes are forwarded.
- Halfword write @0x21 (misaligned) → HREADYOUT 0 then 1 with HRESP = 1 for both cycles; ram_we stays 0; the memory word is unchanged.
- Word access @0x104 with ADDR_WIDTH = 6 → aliases to word 1; a read returns the contents of 0x04.
